// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch over a req/rvalid handshake
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [2:0]  pc_isize_i,
    input  logic [31:0] rs1_data_i,
    input  logic        cond_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_data_o,
    output logic        instr_valid_o,
    output logic        halted_o,
    output logic [31:0] instret_o
);
    localparam logic [1:0] ST_RESET = 2'd0, ST_FETCH = 2'd1, ST_EXEC = 2'd2, ST_HALT = 2'd3;
    localparam logic [2:0] SEL_PC_IMM = 3'd2, SEL_RS1_IMM = 3'd3, SEL_COND = 3'd4;
    logic [1:0]  r_state;
    logic [31:0] r_pc, r_data, r_instret;
    logic        r_valid, r_halted;
    logic [31:0] w_seq, w_rel, w_jmp, w_target;
    logic        w_commit;
    assign w_seq    = r_pc + {29'd0, pc_isize_i};
    assign w_rel    = r_pc + pc_next_off_i;
    assign w_jmp    = (rs1_data_i + pc_next_off_i) & ~32'h1;
    assign w_target = pc_next_sel_i == SEL_PC_IMM  ? w_rel :
                      pc_next_sel_i == SEL_RS1_IMM ? w_jmp :
                      pc_next_sel_i == SEL_COND    ? (cond_i ? w_rel : w_seq) : w_seq;
    // selects 5-7 fall through as STALL
    assign w_commit = r_state == ST_EXEC && pc_next_sel_i != 3'd0 && pc_next_sel_i <= SEL_COND;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RESET;
            r_pc      <= RESET_PC;
            r_data    <= NOP_INSN;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_FETCH;
                ST_FETCH: if (imem_rvalid_i) begin
                    r_data  <= imem_rdata_i;
                    r_valid <= 1'b1;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: if (w_commit) begin
                    r_pc      <= w_target;
                    r_instret <= r_instret + 32'd1;
                    r_valid   <= 1'b0;
                    r_data    <= NOP_INSN;
                    r_state   <= w_target[1:0] == 2'b00 ? ST_FETCH : ST_HALT;
                    r_halted  <= w_target[1:0] != 2'b00;
                end
                default: ;
            endcase
        end
    end
    assign imem_req_o    = r_state == ST_FETCH;
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign pc_data_o     = r_data;
    assign instr_valid_o = r_valid;
    assign halted_o      = r_halted;
    assign instret_o     = r_instret;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch handshake, PC selection, stall, halt and reset
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  pc_next_sel_i = 3'd0;
    logic [31:0] pc_next_off_i = 32'd0;
    logic [2:0]  pc_isize_i = 3'd4;
    logic [31:0] rs1_data_i = 32'd0;
    logic        cond_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic [31:0] pc_o, pc_data_o, instret_o;
    logic        instr_valid_o, halted_o;
    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INSN(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pc_next_sel_i(pc_next_sel_i), .pc_next_off_i(pc_next_off_i),
        .pc_isize_i(pc_isize_i), .rs1_data_i(rs1_data_i), .cond_i(cond_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o), .pc_data_o(pc_data_o), .instr_valid_o(instr_valid_o),
        .halted_o(halted_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] insn, input int waits);
        chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
        chk("fetch_addr", imem_addr_o, a);
        tick();
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, imem_req_o}, 32'd1);
            chk("wait_addr", imem_addr_o, a);
            tick();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = insn;
        tick();
        imem_rvalid_i = 1'b0;
        chk("got_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("got_data", pc_data_o, insn);
        chk("got_pc", pc_o, a);
        chk("got_noreq", {31'd0, imem_req_o}, 32'd0);
    endtask

    task automatic exec(input logic [2:0] sel, input logic [31:0] off, input logic [31:0] rs1, input logic c);
        pc_next_sel_i = sel;
        pc_next_off_i = off;
        rs1_data_i    = rs1;
        cond_i        = c;
        tick();
        pc_next_sel_i = 3'd0;
    endtask

    task automatic after_commit(input logic [31:0] pc, input logic [31:0] ret);
        chk("cm_pc", pc_o, pc);
        chk("cm_instret", instret_o, ret);
        chk("cm_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("cm_data", pc_data_o, NOP);
        chk("cm_halt", {31'd0, halted_o}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pc", pc_o, 32'h100);
        chk("rst_addr", imem_addr_o, 32'h100);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_data", pc_data_o, NOP);
        chk("rst_halt", {31'd0, halted_o}, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        rst_i = 1'b0;
        chk("reset_state_noreq", {31'd0, imem_req_o}, 32'd0);
        tick();
        do_fetch(32'h100, 32'h0000_0013, 1);
        exec(3'd1, 32'd0, 32'd0, 1'b0);
        after_commit(32'h104, 32'd1);
        do_fetch(32'h104, 32'hAAAA_0001, 0);
        exec(3'd2, 32'h0000_00FC, 32'd0, 1'b0);
        after_commit(32'h200, 32'd2);
        do_fetch(32'h200, 32'h0000_0063, 0);
        exec(3'd4, 32'hFFFF_FFF0, 32'd0, 1'b1);
        after_commit(32'h1F0, 32'd3);
        do_fetch(32'h1F0, 32'h0000_006F, 0);
        exec(3'd2, 32'h0000_0010, 32'd0, 1'b0);
        after_commit(32'h200, 32'd4);
        do_fetch(32'h200, 32'h0000_0063, 0);
        exec(3'd4, 32'hFFFF_FFF0, 32'd0, 1'b0);
        after_commit(32'h204, 32'd5);
        do_fetch(32'h204, 32'h0000_0067, 0);
        exec(3'd3, 32'h0000_0007, 32'h0000_1001, 1'b0);
        after_commit(32'h1008, 32'd6);
        do_fetch(32'h1008, 32'h1234_5678, 2);
        for (int i = 0; i < 3; i++) begin
            pc_next_sel_i = i == 2 ? 3'd7 : 3'd0;
            tick();
            chk("stall_pc", pc_o, 32'h1008);
            chk("stall_data", pc_data_o, 32'h1234_5678);
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
            chk("stall_instret", instret_o, 32'd6);
        end
        exec(3'd1, 32'd0, 32'd0, 1'b0);
        after_commit(32'h100C, 32'd7);
        do_fetch(32'h100C, 32'h0000_0013, 0);
        exec(3'd2, 32'hFFFF_EFF0, 32'd0, 1'b0);
        after_commit(32'hFFFF_FFFC, 32'd8);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
        exec(3'd1, 32'd0, 32'd0, 1'b0);
        after_commit(32'h0, 32'd9);
        chk("wrap_req", {31'd0, imem_req_o}, 32'd1);
        chk("wrap_addr", imem_addr_o, 32'h0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_req", {31'd0, imem_req_o}, 32'd0);
        chk("mid_pc", pc_o, 32'h100);
        chk("mid_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mid_instret", instret_o, 32'd0);
        tick();
        pc_next_sel_i = 3'd1;
        do_fetch(32'h100, 32'h0000_0013, 1);
        pc_next_sel_i = 3'd0;
        exec(3'd3, 32'h0000_0001, 32'h0000_1001, 1'b0);
        chk("halt_flag", {31'd0, halted_o}, 32'd1);
        chk("halt_pc", pc_o, 32'h1002);
        chk("halt_req", {31'd0, imem_req_o}, 32'd0);
        chk("halt_instret", instret_o, 32'd1);
        chk("halt_data", pc_data_o, NOP);
        pc_next_sel_i = 3'd1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'd0, imem_req_o}, 32'd0);
            chk("hold_pc", pc_o, 32'h1002);
            chk("hold_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("hold_data", pc_data_o, NOP);
            chk("hold_halt", {31'd0, halted_o}, 32'd1);
        end
        imem_rvalid_i = 1'b0;
        pc_next_sel_i = 3'd0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("unhalt", {31'd0, halted_o}, 32'd0);
        chk("unhalt_pc", pc_o, 32'h100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and PC sequencing stage, directly upstream of the decode/control block.
- Holds the architectural PC and fetches instructions over a simple instruction-memory request/valid handshake.
- Presents a stable instruction word to control on pc_data_o.
- Consumes control's next-PC selection (pc_next_sel/off/isize), the branch condition and rs1 to compute and commit the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSN, 32'h0000_0013, word driven on pc_data_o while no valid instruction is held (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pc_next_sel_i  in  3  next-PC select from control: STALL=0, NEXT=1, PC_IMM=2, RS1_IMM=3, COND_PC_IMM=4 (PC_NEXT_SEL_* in const.v)
- pc_next_off_i  in  32  sign-extended offset from control
- pc_isize_i  in  3  instruction size in bytes (4 for RV32I)
- rs1_data_i  in  32  register-file rs1 read data (JALR base)
- cond_i  in  1  branch condition, ALU result bit 0
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_rvalid_i  in  1  fetch data valid
- imem_rdata_i  in  32  fetched instruction
- pc_o  out  32  PC of the held instruction
- pc_data_o  out  32  held instruction, to control
- instr_valid_o  out  1  pc_data_o holds a fetched instruction
- halted_o  out  1  sticky misaligned-target halt
- instret_o  out  32  retired-instruction counter

Behaviour:
- All registers update on posedge clk_i. rst_i sampled at the edge has priority over everything.
- Reset values:
  - state=ST_RESET; pc_o=RESET_PC; imem_addr_o=RESET_PC
  - pc_data_o=NOP_INSN; instr_valid_o=0; imem_req_o=0
  - halted_o=0; instret_o=0
- States: ST_RESET, ST_FETCH, ST_EXEC, ST_HALT.
- ST_RESET:
  - Lasts one cycle, then goes to ST_FETCH.
  - imem_addr_o=pc_o.
- ST_FETCH:
  - imem_req_o=1; imem_addr_o=pc_o, held stable.
  - Memory samples req at a clock edge; imem_rvalid_i may assert no earlier than the following cycle, with arbitrary wait states.
  - rvalid is ignored when req=0.
  - On the edge where imem_req_o=1 and imem_rvalid_i=1: pc_data_o<=imem_rdata_i; instr_valid_o<=1; state<=ST_EXEC.
  - Only one transaction is outstanding at any time.
- ST_EXEC:
  - imem_req_o=0. pc_next_sel_i is honoured only here; it is ignored in all other states.
  - STALL: hold pc_o, pc_data_o and state. This covers control's load stall.
  - NEXT: target = pc_o + zero-extended pc_isize_i.
  - PC_IMM: target = pc_o + pc_next_off_i.
  - RS1_IMM: target = (rs1_data_i + pc_next_off_i) & ~32'h1.
  - COND_PC_IMM: target = cond_i ? pc_o + pc_next_off_i : pc_o + pc_isize_i.
  - Values 5–7 are treated as STALL.
  - All target arithmetic is mod 2^32; wrap from 0xFFFF_FFFC to 0 is legal.
  - On a non-STALL commit, at the same edge:
    - pc_o<=target; instret_o<=instret_o+1 (wraps).
    - instr_valid_o<=0; pc_data_o<=NOP_INSN.
    - If target[1:0]==0: state<=ST_FETCH.
    - Otherwise: state<=ST_HALT; halted_o<=1. pc_o still takes the faulting target, for debug.
- ST_HALT:
  - imem_req_o=0; instr_valid_o=0; pc_data_o=NOP_INSN.
  - Exits only on rst_i.
- Latency:
  - Reset deassert to first req: 1 cycle.
  - Commit edge to next req: 0 cycles (req high in the cycle after the commit).
  - Zero-wait memory gives 3 cycles per non-stalling instruction: FETCH, rvalid, EXEC.
- Reset mid-fetch: req drops at the reset edge. The instruction memory shares rst_i and discards any pending response.
- instr_valid_o=0 guarantees control sees a NOP, so no register write, no memory write, and no PC effect.

Test Plan:
- Reset with RESET_PC=0x100, memory returns 0x00000013 after 1 wait cycle, control drives NEXT/isize 4 -> req addr 0x100, then 0x104; instret_o=1 after the first commit.
- In EXEC at pc 0x200, COND_PC_IMM with off=0xFFFFFFF0: cond_i=1 -> next fetch addr 0x1F0; cond_i=0 -> 0x204.
- RS1_IMM with rs1=0x1001, off=0x7 -> target 0x1008, fetch 0x1008; with rs1=0x1001, off=0x1 -> target 0x1002 -> halted_o=1, req stays 0, pc_o=0x1002.
- STALL held 3 cycles in EXEC, then NEXT -> pc_o and pc_data_o unchanged for 3 cycles, instret increments once, no req during the stall.
- rst_i asserted while req=1 and rvalid not yet returned -> next cycle req=0, pc_o=RESET_PC, instr_valid_o=0, instret_o=0; a fetch restarts after 1 cycle.
- pc 0xFFFFFFFC with NEXT -> pc_o=0x00000000, fetch addr 0x0, no halt.
